bist_seq: RTL and testbench

Parametrised BIST sequencer, successor to the TAP-attached BIST engine. It holds a test-vector memory loaded from the TAP data-register path and replays the stimulus to the device under test. It compares masked responses against expected values through a configurable response-latency pipeline and reports pass/fail, error count and first-failure capture to the TAP status register. It adds two run modes (stop-on-first-fail or run-to-end), per-vector masking and an explicit end-of-test marker.

---
 rtl/bist_seq.sv | 219 +++++++++++++++++++++
 tb/tb_bist_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_seq.sv
// bist_seq -- BIST sequencer with a TAP-loaded test-vector memory.
//
// Vectors {stim, exp, mask, last} are written during a load session.
// RUN replays them one per cycle on dut_stim. Each issued vector's
// {exp, mask, index} travels down a RESP_LAT-deep delay line, so it
// reaches the head exactly when dut_resp for that vector is valid.
// The head is then compared under the mask, and errors, the first
// failure and an optional signature are recorded.
//
// Optional feature: define BIST_SEQ_SIGNATURE_EN to build the 16-bit
// response MISR. Without it, signature is tied to zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tlr               synchronous soft reset (vector memory kept)
//   load_en           load session active
//   load_valid        write one vector
//   load_stim/exp/mask/last
//                     vector fields
//   run_start, mode   start pulse; 0 = stop on first fail, 1 = run to end
//   dut_stim/dut_resp stimulus out, response in
//   busy, done, fail, load_ovf
//                     status flags
//   vec_count         number of vectors loaded
//   err_cnt           saturating mismatch count
//   fail_addr/fail_resp
//                     capture of the first failure
//   signature         MISR value, or 0 when the MISR is not built
module bist_seq #(
   parameter  int unsigned DEPTH    = 256,
   parameter  int unsigned STIM_W   = 4,
   parameter  int unsigned RESP_W   = 4,
   parameter  int unsigned RESP_LAT = 2,
   parameter  int unsigned ERRCNT_W = 8,
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tlr,
   input  logic                load_en,
   input  logic                load_valid,
   input  logic [STIM_W-1:0]   load_stim,
   input  logic [RESP_W-1:0]   load_exp,
   input  logic [RESP_W-1:0]   load_mask,
   input  logic                load_last,
   input  logic                run_start,
   input  logic                mode,
   output logic [STIM_W-1:0]   dut_stim,
   input  logic [RESP_W-1:0]   dut_resp,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic                load_ovf,
   output logic [AW:0]         vec_count,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic [AW-1:0]       fail_addr,
   output logic [RESP_W-1:0]   fail_resp,
   output logic [15:0]         signature
);

   localparam int unsigned H       = RESP_LAT - 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [STIM_W-1:0] stim;
      logic [RESP_W-1:0] exp;
      logic [RESP_W-1:0] mask;
      logic              last;
   } vec_t;

   typedef struct packed {
      logic [RESP_W-1:0] exp;
      logic [RESP_W-1:0] mask;
      logic [AW-1:0]     idx;
   } line_t;

   state_t              state, nxt;
   vec_t                mem [DEPTH];
   vec_t                cur;
   logic [AW-1:0]       pc;
   logic                mode_q;
   logic [RESP_LAT-1:0] dl_valid;
   line_t               dl_q [RESP_LAT];
   line_t               head;
   logic                idle_like, load_go, run_go, wr_en;
   logic                mismatch, stop, issue, last_vec;

   assign cur       = mem[pc];
   assign head      = dl_q[H];
   assign idle_like = (state == IDLE) || (state == DONE);
   assign load_go   = idle_like && load_en;
   assign run_go    = idle_like && run_start && !load_en;
   assign wr_en     = (state == LOAD) && load_valid && (vec_count != DEPTH_C) && !tlr;
   assign mismatch  = dl_valid[H] && (|((dut_resp ^ head.exp) & head.mask));
   // In stop-on-fail mode the first mismatch halts issue on the same edge.
   assign stop      = mismatch && !mode_q;
   assign issue     = (state == RUN) && !stop;
   assign last_vec  = cur.last || ({1'b0, pc} == (vec_count - 1'b1));

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (load_en)        nxt = LOAD;
            else if (run_start) nxt = (vec_count == '0) ? DONE : RUN;
         end
         LOAD:  if (!load_en)         nxt = IDLE;
         // A stop-on-fail abort also passes through DRAIN: the delay line
         // is flushed at that edge, so DONE follows one cycle later.
         RUN:   if (stop || last_vec) nxt = DRAIN;
         DRAIN: if (dl_valid == '0)   nxt = DONE;
         default:                     nxt = IDLE;
      endcase
   end

   // Vector memory has no reset; its contents survive tlr.
   always_ff @(posedge clk) begin
      if (wr_en) mem[vec_count[AW-1:0]] <= {load_stim, load_exp, load_mask, load_last};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec_count <= '0;
         load_ovf  <= 1'b0;
         pc        <= '0;
         mode_q    <= 1'b0;
         dut_stim  <= '0;
         err_cnt   <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_resp <= '0;
         dl_valid  <= '0;
         for (int unsigned i = 0; i < RESP_LAT; i++) dl_q[i] <= '0;
      end else if (tlr) begin
         // vec_count describes the retained memory, so it survives tlr.
         state     <= IDLE;
         load_ovf  <= 1'b0;
         pc        <= '0;
         mode_q    <= 1'b0;
         dut_stim  <= '0;
         err_cnt   <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_resp <= '0;
         dl_valid  <= '0;
      end else begin
         state <= nxt;

         if (load_go) begin
            vec_count <= '0;
            load_ovf  <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
         end

         if ((state == LOAD) && load_valid) begin
            if (vec_count == DEPTH_C) load_ovf  <= 1'b1;
            else                      vec_count <= vec_count + 1'b1;
         end

         if (run_go) begin
            pc        <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_resp <= '0;
            mode_q    <= mode;
         end

         if (issue) begin
            dut_stim <= cur.stim;
            pc       <= pc + 1'b1;
         end

         for (int unsigned i = 1; i < RESP_LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_q[i]     <= dl_q[i-1];
         end
         dl_valid[0] <= issue;
         dl_q[0]     <= {cur.exp, cur.mask, pc};
         if (stop) dl_valid <= '0;

         if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!fail) begin
               fail      <= 1'b1;
               fail_addr <= head.idx;
               fail_resp <= dut_resp;
            end
         end
      end
   end

`ifdef BIST_SEQ_SIGNATURE_EN
   logic [15:0] sig_q;

   // Only valid compares update the MISR, so it is frozen in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (tlr || run_go) begin
         sig_q <= '0;
      end else if (dl_valid[H]) begin
         sig_q <= {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ 16'(dut_resp);
      end
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

endmodule

// File: tb/tb_bist_seq.sv
// tb_bist_seq -- randomized scoreboard bench for bist_seq.
// The stimulus side loads vectors and starts runs. For each run it
// computes the expected outcome from the vector list and queues it.
// A monitor pops one entry on each rising edge of done and compares.
// The DUT is modelled as a loopback with RESP_LAT delay and a per-vector
// XOR corruption pattern.
module tb_bist_seq;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned STIM_W   = 4;
   localparam int unsigned RESP_W   = 4;
   localparam int unsigned RESP_LAT = 3;
   localparam int unsigned ERRCNT_W = 2;
   localparam int unsigned AW       = 3;
   localparam int unsigned ERR_MAX  = (1 << ERRCNT_W) - 1;

   logic                clk = 1'b0, rst_n = 1'b0, tlr = 1'b0;
   logic                load_en = 1'b0, load_valid = 1'b0, load_last = 1'b0;
   logic                run_start = 1'b0, mode = 1'b0;
   logic [STIM_W-1:0]   load_stim = '0;
   logic [RESP_W-1:0]   load_exp = '0, load_mask = '0, dut_resp = '0;
   logic [STIM_W-1:0]   dut_stim;
   logic                busy, done, fail, load_ovf;
   logic [AW:0]         vec_count;
   logic [ERRCNT_W-1:0] err_cnt;
   logic [AW-1:0]       fail_addr;
   logic [RESP_W-1:0]   fail_resp;
   logic [15:0]         signature;

   bist_seq #(.DEPTH(DEPTH), .STIM_W(STIM_W), .RESP_W(RESP_W),
              .RESP_LAT(RESP_LAT), .ERRCNT_W(ERRCNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .tlr(tlr),
      .load_en(load_en), .load_valid(load_valid), .load_stim(load_stim),
      .load_exp(load_exp), .load_mask(load_mask), .load_last(load_last),
      .run_start(run_start), .mode(mode),
      .dut_stim(dut_stim), .dut_resp(dut_resp),
      .busy(busy), .done(done), .fail(fail), .load_ovf(load_ovf),
      .vec_count(vec_count), .err_cnt(err_cnt), .fail_addr(fail_addr),
      .fail_resp(fail_resp), .signature(signature)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // staging area for the next load, and the reference memory
   logic [3:0] ld_stim [16], ld_exp [16], ld_mask [16];
   logic       ld_last [16];
   logic [3:0] m_stim [DEPTH], m_exp [DEPTH], m_mask [DEPTH];
   logic       m_last [DEPTH];
   int         m_count = 0;
   logic [3:0] xor_pat [DEPTH];

   typedef struct {
      int          cyc;
      logic        fail;
      int          err;
      int          faddr;
      logic [3:0]  fresp;
      logic [3:0]  stim;
      bit          stim_chk;
      logic [15:0] sig;
   } exp_t;
   exp_t sb[$];

   // DUT behaviour: loopback delayed by RESP_LAT, with optional corruption
   int         cyc = 0;
   int         run_t = -1000;
   int         n_active = 0;
   logic [3:0] hist[$];
   int         mk;
   logic [3:0] mr;

   always @(posedge clk) begin
      cyc++;
      #1;
      hist.push_front(dut_stim);
      if (hist.size() > 8) void'(hist.pop_back());
      mr = (hist.size() >= RESP_LAT) ? hist[RESP_LAT-1] : 4'h0;
      mk = cyc - int'(RESP_LAT - 1) - (run_t + 1);
      if (mk >= 0 && mk < n_active) mr = mr ^ xor_pat[mk];
      dut_resp = mr;
   end

   // monitor: one scoreboard entry per rising edge of done
   logic prev_done = 1'b0;
   exp_t me;
   always @(negedge clk) begin
      if (done && !prev_done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            me = sb.pop_front();
            chk("done_cycle", cyc, me.cyc);
            chk("busy_at_done", busy, 0);
            chk("fail", fail, me.fail);
            chk("err_cnt", err_cnt, me.err);
            if (me.fail) begin
               chk("fail_addr", fail_addr, me.faddr);
               chk("fail_resp", fail_resp, me.fresp);
            end
            chk("signature", signature, me.sig);
            if (me.stim_chk) chk("dut_stim_hold", dut_stim, me.stim);
         end
      end
      prev_done = done;
   end

   task automatic set_vec(input int i, input logic [3:0] s, input logic [3:0] e,
                          input logic [3:0] m, input logic l);
      ld_stim[i] = s; ld_exp[i] = e; ld_mask[i] = m; ld_last[i] = l;
   endtask

   task automatic do_load(input int n);
      @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_stim = ld_stim[i]; load_exp = ld_exp[i];
         load_mask = ld_mask[i]; load_last = ld_last[i];
         if (i < int'(DEPTH)) begin
            m_stim[i] = ld_stim[i]; m_exp[i] = ld_exp[i];
            m_mask[i] = ld_mask[i]; m_last[i] = ld_last[i];
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      load_en = 1'b0;
      m_count = (n > int'(DEPTH)) ? int'(DEPTH) : n;
      @(negedge clk);
      chk("vec_count", vec_count, m_count);
      chk("load_ovf", load_ovf, (n > int'(DEPTH)) ? 1 : 0);
      chk("idle_after_load", {busy, done}, 0);
   endtask

   task automatic do_run(input logic md);
      exp_t        e;
      int          lim, last_i, errs;
      logic [3:0]  r;
      logic [15:0] sg;
      logic        fl;
      lim = m_count;
      for (int k = 0; k < m_count; k++) begin
         if (m_last[k]) begin
            lim = k + 1;
            break;
         end
      end
      @(negedge clk);
      run_start = 1'b1;
      mode = md;
      run_t = cyc + 1;
      n_active = lim;
      errs = 0; fl = 1'b0; sg = '0; last_i = lim - 1;
      e.faddr = 0; e.fresp = '0;
      e.cyc = (lim == 0) ? run_t : run_t + lim + int'(RESP_LAT) + 1;
      for (int k = 0; k < lim; k++) begin
         r = m_stim[k] ^ xor_pat[k];
`ifdef BIST_SEQ_SIGNATURE_EN
         sg = {sg[14:0], sg[15] ^ sg[13] ^ sg[12] ^ sg[10]} ^ {12'h000, r};
`endif
         if (((r ^ m_exp[k]) & m_mask[k]) != 4'h0) begin
            if (errs < int'(ERR_MAX)) errs++;
            if (!fl) begin
               fl = 1'b1; e.faddr = k; e.fresp = r;
            end
            if (!md) begin
               e.cyc = run_t + 1 + k + int'(RESP_LAT) + 1;
               if (k + int'(RESP_LAT) - 1 < lim - 1) last_i = k + int'(RESP_LAT) - 1;
               break;
            end
         end
      end
      e.fail = fl; e.err = errs; e.sig = sg;
      e.stim_chk = (lim > 0);
      e.stim = '0;
      if (lim > 0) e.stim = m_stim[last_i];
      sb.push_back(e);
      @(negedge clk);
      run_start = 1'b0;
      for (int w = 0; w < 60 && !done; w++) @(negedge clk);
      chk("done_seen", done, 1);
      @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
   endtask

   task automatic run_nocheck(input logic md);
      @(negedge clk);
      run_start = 1'b1;
      mode = md;
      run_t = cyc + 1;
      n_active = m_count;
      @(negedge clk);
      run_start = 1'b0;
   endtask

   task automatic clear_xor();
      for (int i = 0; i < int'(DEPTH); i++) xor_pat[i] = 4'h0;
   endtask

   task automatic basic4(input logic [3:0] m, input logic last1);
      for (int i = 0; i < 4; i++) set_vec(i, 4'(i + 1), 4'(i + 1), m, (i == 1) ? last1 : 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      clear_xor();
      repeat (3) @(negedge clk);
      chk("reset_outputs", {busy, done, fail, load_ovf, vec_count, err_cnt,
                            fail_addr, fail_resp, dut_stim}, 0);
      chk("reset_signature", signature, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {busy, done, fail}, 0);

      // plain loopback, 4 vectors
      basic4(4'hF, 1'b0);
      do_load(4);
      do_run(1'b0);

      // stop-on-fail at vector 2 (response forced to 0)
      xor_pat[2] = 4'h3;
      do_run(1'b0);

      // run-to-end with faults on vectors 1 and 3
      clear_xor();
      xor_pat[1] = 4'h2; xor_pat[3] = 4'h4;
      do_run(1'b1);

      // bit-3 errors masked off, end marker on vector 1
      for (int i = 0; i < 4; i++) xor_pat[i] = 4'h8;
      basic4(4'h7, 1'b1);
      do_load(4);
      do_run(1'b0);

      // error counter saturation: every vector wrong
      for (int i = 0; i < int'(DEPTH); i++) begin
         set_vec(i, 4'($urandom), 4'h0, 4'hF, 1'b0);
         ld_exp[i] = ~ld_stim[i];
      end
      clear_xor();
      do_load(8);
      do_run(1'b1);

      // overflow: 9th write dropped, the first 8 replay cleanly
      for (int i = 0; i < 9; i++) begin
         set_vec(i, 4'($urandom), 4'h0, 4'hF, 1'b0);
         ld_exp[i] = ld_stim[i];
      end
      do_load(9);
      do_run(1'b1);

      // randomized loads and runs
      for (int it = 0; it < 12; it++) begin
         int n;
         n = $urandom_range(1, 9);
         clear_xor();
         for (int i = 0; i < n; i++) begin
            set_vec(i, 4'($urandom), 4'h0, 4'($urandom), ($urandom_range(0, 7) == 0));
            ld_exp[i] = ld_stim[i];
            if (i < int'(DEPTH) && $urandom_range(0, 3) == 0) xor_pat[i] = 4'($urandom_range(1, 15));
         end
         do_load(n);
         do_run(1'($urandom_range(0, 1)));
      end

      // tlr mid-RUN, then a rerun from retained memory
      for (int i = 0; i < 6; i++) set_vec(i, 4'($urandom), 4'h0, 4'hF, 1'b0);
      for (int i = 0; i < 6; i++) ld_exp[i] = ld_stim[i];
      clear_xor();
      xor_pat[0] = 4'hF;
      do_load(6);
      run_nocheck(1'b1);
      repeat (5) @(negedge clk);
      chk("busy_before_tlr", busy, 1);
      chk("err_before_tlr", err_cnt, 1);
      tlr = 1'b1;
      @(negedge clk);
      tlr = 1'b0;
      chk("tlr_flags", {busy, done, fail}, 0);
      chk("tlr_err_cnt", err_cnt, 0);
      chk("tlr_vec_count", vec_count, 6);
      clear_xor();
      do_run(1'b0);

      // asynchronous reset in DRAIN
      basic4(4'hF, 1'b0);
      do_load(4);
      xor_pat[0] = 4'hF;
      run_nocheck(1'b1);
      repeat (5) @(negedge clk);
      chk("busy_in_drain", busy, 1);
      chk("err_in_drain", err_cnt, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {busy, done, fail, load_ovf, vec_count, err_cnt,
                                  fail_addr, fail_resp, dut_stim}, 0);
      chk("async_reset_signature", signature, 0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_xor();
      m_count = 0;

      // run with no vectors loaded
      do_run(1'b0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
